block_stream_tx: RTL and testbench

- Transmit end of the block-stream interface that the modular-arithmetic blocks consume (valid_in plus a REGISTER_SIZE-wide num_in, least-significant block first, BITS_IN_NUM/REGISTER_SIZE blocks per number).
- Host or control logic writes a full number into internal storage through a random-access word port.
- On start_in, the block replays the stored number as a contiguous valid-qualified block stream, with last/done markers.
- Sits in front of the mod_n, multiplier, divider and subtractor chains; also used as a test stimulus source.

---
 rtl/block_stream_tx.sv | 183 ++++++++++++++++++
 tb/tb_block_stream_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_stream_tx.sv
// block_stream_tx: stores a BITS_IN_NUM-wide number as REGISTER_SIZE blocks and replays it,
// least-significant block first, as a valid/last/done qualified stream. Option: BLOCK_STREAM_TX_GAP_EN.
module block_stream_tx #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 4096
) (
    input  logic                                         clk_in,
    input  logic                                         rst_n_in,
    input  logic                                         wr_en_in,
    input  logic [$clog2(BITS_IN_NUM/REGISTER_SIZE)-1:0] wr_addr_in,
    input  logic [REGISTER_SIZE-1:0]                     wr_data_in,
    input  logic                                         start_in,
`ifdef BLOCK_STREAM_TX_GAP_EN
    input  logic [7:0]                                   gap_in,
`endif
    output logic                                         busy_out,
    output logic                                         valid_out,
    output logic [REGISTER_SIZE-1:0]                     data_out,
    output logic                                         last_out,
    output logic                                         done_out,
    output logic                                         wr_err_out
);

    localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int AW         = $clog2(NUM_BLOCKS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_BLOCKS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [REGISTER_SIZE-1:0] mem_q [NUM_BLOCKS];
    logic [REGISTER_SIZE-1:0] ram_q;

    logic [1:0]               state_q, state_d;
    logic [AW-1:0]            raddr_q, raddr_d;
    logic [AW-1:0]            bidx_q, bidx_d;
    logic                     busy_q, busy_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [REGISTER_SIZE-1:0] data_q, data_d;

    logic                     wr_ok;
    logic                     wr_drop;
    logic                     start_ok;
    logic                     rd_en;
    logic                     emit;
    logic [AW-1:0]            raddr_next;

    assign wr_ok      = wr_en_in & ~busy_q;
    assign wr_drop    = wr_en_in & busy_q;
    assign start_ok   = start_in & (state_q == S_IDLE);
    assign raddr_next = (raddr_q == LAST_IDX) ? raddr_q : raddr_q + AW'(1);

    // Storage is deliberately left out of reset. The read register only advances when a
    // block is consumed, so it keeps holding the next block across gap cycles.
    always_ff @(posedge clk_in) begin
        if (wr_ok) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
        if (rd_en) begin
            ram_q <= mem_q[raddr_q];
        end
    end

`ifdef BLOCK_STREAM_TX_GAP_EN
    logic [7:0] gap_q, gap_q_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;

    assign emit = (gap_cnt_q == 8'd0);

    always_comb begin
        gap_q_d   = gap_q;
        gap_cnt_d = gap_cnt_q;
        if (start_ok) begin
            gap_q_d   = gap_in;
            gap_cnt_d = 8'd0;
        end else if (state_q == S_STREAM) begin
            gap_cnt_d = emit ? gap_q : gap_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            gap_q     <= 8'd0;
            gap_cnt_q <= 8'd0;
        end else begin
            gap_q     <= gap_q_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end
`else
    assign emit = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        bidx_d  = bidx_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        data_d  = data_q;
        err_d   = err_q;
        rd_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_PRIME;
                    raddr_d = '0;
                    bidx_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_PRIME: begin
                rd_en   = 1'b1;
                raddr_d = raddr_next;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (emit) begin
                    rd_en   = 1'b1;
                    raddr_d = raddr_next;
                    valid_d = 1'b1;
                    data_d  = ram_q;
                    if (bidx_q == LAST_IDX) begin
                        last_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        bidx_d = bidx_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A dropped write wins over the clear from a start accepted in the same cycle.
        if (wr_drop) begin
            err_d = 1'b1;
        end
        busy_d = (state_d != S_IDLE) | done_d;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            raddr_q <= '0;
            bidx_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            bidx_q  <= bidx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign busy_out   = busy_q;
    assign valid_out  = valid_q;
    assign data_out   = data_q;
    assign last_out   = last_q;
    assign done_out   = done_q;
    assign wr_err_out = err_q;

endmodule

// File: tb/tb_block_stream_tx.sv
// tb_block_stream_tx: table vectors, directed corner sequences and a randomized run against
// a start-time/arithmetic reference model, for block_stream_tx with NUM_BLOCKS=4.
module tb_block_stream_tx;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        wr_en_in = 1'b0;
    logic [1:0]  wr_addr_in = 2'd0;
    logic [31:0] wr_data_in = 32'd0;
    logic        start_in = 1'b0;
`ifdef BLOCK_STREAM_TX_GAP_EN
    logic [7:0]  gap_in = 8'd0;
`endif
    logic        busy_out, valid_out, last_out, done_out, wr_err_out;
    logic [31:0] data_out;

    block_stream_tx #(.REGISTER_SIZE(32), .BITS_IN_NUM(128)) dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n_in),
        .wr_en_in   (wr_en_in),
        .wr_addr_in (wr_addr_in),
        .wr_data_in (wr_data_in),
        .start_in   (start_in),
`ifdef BLOCK_STREAM_TX_GAP_EN
        .gap_in     (gap_in),
`endif
        .busy_out   (busy_out),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .last_out   (last_out),
        .done_out   (done_out),
        .wr_err_out (wr_err_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream monitor, sampled mid-cycle.
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          ndone = 0;
    always @(negedge clk) begin
        if (rst_n_in) begin
            if (valid_out) begin
                got_d.push_back(data_out);
                got_l.push_back(last_out);
            end
            if (done_out) ndone++;
        end
    end

    task automatic clr_mon();
        got_d.delete();
        got_l.delete();
        ndone = 0;
    endtask

    function automatic logic [36:0] outs();
        return {busy_out, valid_out, last_out, done_out, wr_err_out, data_out};
    endfunction

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        start;
        logic [36:0] exp;   // {busy, valid, last, done, err, data}
    } vec_t;

    function automatic vec_t mkv(logic wr, logic [1:0] a, logic [31:0] wd, logic st,
                                 logic b, logic v, logic l, logic dn, logic e, logic [31:0] d);
        vec_t r;
        r.wr = wr; r.addr = a; r.wdata = wd; r.start = st;
        r.exp = {b, v, l, dn, e, d};
        return r;
    endfunction

    function automatic int done_edge(int s, int g);
        return s + 2 + NB + (NB - 1) * g;
    endfunction

    vec_t tbl[13];

    // Reference model state
    int          s_m, g_m, n_m, dd, k;
    logic [31:0] mmem[NB];
    logic [31:0] snap[NB];
    logic [31:0] mdata;
    logic        merr, busy_prev, ev, el, eb, edn;
    logic        rw, rst_;
    logic [1:0]  ra;
    logic [31:0] rd;
    int          gd;
    logic [9:0]  pat;

    initial begin
        tbl[0]  = mkv(1, 2'd0, 32'h11111111, 0,  0, 0, 0, 0, 0, 32'h0);
        tbl[1]  = mkv(1, 2'd1, 32'h22222222, 0,  0, 0, 0, 0, 0, 32'h0);
        tbl[2]  = mkv(1, 2'd2, 32'h33333333, 0,  0, 0, 0, 0, 0, 32'h0);
        tbl[3]  = mkv(1, 2'd3, 32'h44444444, 0,  0, 0, 0, 0, 0, 32'h0);
        tbl[4]  = mkv(0, 2'd0, 32'h0,        1,  1, 0, 0, 0, 0, 32'h0);          // t
        tbl[5]  = mkv(0, 2'd0, 32'h0,        0,  1, 0, 0, 0, 0, 32'h0);          // t+1
        tbl[6]  = mkv(0, 2'd0, 32'h0,        0,  1, 1, 0, 0, 0, 32'h11111111);   // t+2
        tbl[7]  = mkv(0, 2'd0, 32'h0,        0,  1, 1, 0, 0, 0, 32'h22222222);
        tbl[8]  = mkv(0, 2'd0, 32'h0,        0,  1, 1, 0, 0, 0, 32'h33333333);
        tbl[9]  = mkv(0, 2'd0, 32'h0,        0,  1, 1, 1, 0, 0, 32'h44444444);   // t+5
        tbl[10] = mkv(0, 2'd0, 32'h0,        0,  1, 0, 0, 1, 0, 32'h44444444);   // t+6
        tbl[11] = mkv(0, 2'd0, 32'h0,        0,  0, 0, 0, 0, 0, 32'h44444444);
        tbl[12] = mkv(0, 2'd0, 32'h0,        0,  0, 0, 0, 0, 0, 32'h44444444);

        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'(outs()), 64'd0);
        rst_n_in = 1'b1;

        // Basic stream, cycle by cycle
        for (int i = 0; i < 13; i++) begin
            wr_en_in = tbl[i].wr; wr_addr_in = tbl[i].addr;
            wr_data_in = tbl[i].wdata; start_in = tbl[i].start;
            tick();
            chk($sformatf("basic_vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
        end
        wr_en_in = 0; start_in = 0;

        // Write while busy is dropped and flagged; next start clears the flag
        clr_mon();
        start_in = 1; tick(); start_in = 0;
        tick(); tick();
        wr_en_in = 1; wr_addr_in = 2'd2; wr_data_in = 32'hDEADBEEF;
        tick(); wr_en_in = 0;
        repeat (5) tick();
        chk("busywr_count", 64'(got_d.size()), 64'd4);
        if (got_d.size() == 4) chk("busywr_blk2", 64'(got_d[2]), 64'h33333333);
        chk("busywr_err", 64'(wr_err_out), 64'd1);
        clr_mon();
        start_in = 1; tick(); start_in = 0;
        chk("err_clear", 64'(wr_err_out), 64'd0);
        repeat (7) tick();
        if (got_d.size() == 4) chk("restream_blk2", 64'(got_d[2]), 64'h33333333);
        else chk("restream_count", 64'(got_d.size()), 64'd4);

        // Same-cycle write and start
        clr_mon();
        wr_en_in = 1; wr_addr_in = 2'd0; wr_data_in = 32'hCAFEF00D; start_in = 1;
        tick(); wr_en_in = 0; start_in = 0;
        repeat (7) tick();
        if (got_d.size() == 4) chk("samecyc_blk0", 64'(got_d[0]), 64'hCAFEF00D);
        else chk("samecyc_count", 64'(got_d.size()), 64'd4);
        wr_en_in = 1; wr_addr_in = 2'd0; wr_data_in = 32'h11111111;
        tick(); wr_en_in = 0;

        // Start while busy is ignored; start at t+7 is accepted
        clr_mon();
        start_in = 1; tick(); start_in = 0;        // t
        tick(); tick();                            // t+1, t+2
        start_in = 1; tick(); tick(); start_in = 0; // t+3, t+4
        tick(); tick();                            // t+5, t+6
        start_in = 1; tick(); start_in = 0;        // t+7
        chk("ignore_count", 64'(got_d.size()), 64'd4);
        chk("ignore_done", 64'(ndone), 64'd1);
        tick();
        chk("second_t8_valid", 64'(valid_out), 64'd0);
        tick();
        chk("second_t9", 64'({valid_out, data_out}), 64'({1'b1, 32'h11111111}));
        repeat (5) tick();
        chk("second_count", 64'(got_d.size()), 64'd8);

        // Asynchronous reset mid-stream
        clr_mon();
        start_in = 1; tick(); start_in = 0;
        repeat (3) tick();
        #2 rst_n_in = 1'b0;
        #1 chk("async_rst", 64'({valid_out, busy_out, last_out}), 64'd0);
        #2 rst_n_in = 1'b1;
        tick();
        clr_mon();
        start_in = 1; tick(); start_in = 0;
        repeat (7) tick();
        chk("post_rst_count", 64'(got_d.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_d.size(); i++)
            chk($sformatf("post_rst_blk%0d", i), 64'(got_d[i]), 64'({4{4'(i + 1), 4'(i + 1)}}));
        chk("post_rst_done", 64'(ndone), 64'd1);

`ifdef BLOCK_STREAM_TX_GAP_EN
        // Gap of 2 idle cycles between blocks
        gap_in = 8'd2; start_in = 1; tick(); start_in = 0; gap_in = 8'd0;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            pat[9 - i] = valid_out;
            if (i == 9) chk("gap_last_t11", 64'(last_out), 64'd1);
        end
        chk("gap_pattern", 64'(pat), 64'b1001001001);
        tick();
        chk("gap_done_t12", 64'(done_out), 64'd1);
        tick();
`endif

        // Randomized run against the reference model
        @(negedge clk) rst_n_in = 1'b0;
        @(negedge clk) rst_n_in = 1'b1;
        s_m = -100; g_m = 0; n_m = 0; mdata = 32'd0; merr = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rw   = (i < NB) || ($urandom_range(3) == 0);
            ra   = (i < NB) ? 2'(i) : 2'($urandom_range(3));
            rd   = $urandom;
            rst_ = (i >= NB) && ($urandom_range(5) == 0);
            gd   = 0;
`ifdef BLOCK_STREAM_TX_GAP_EN
            gd = $urandom_range(3);
            gap_in = 8'(gd);
`endif
            wr_en_in = rw; wr_addr_in = ra; wr_data_in = rd; start_in = rst_;
            tick();
            n_m++;
            busy_prev = (n_m - 1 >= s_m) && (n_m - 1 <= done_edge(s_m, g_m));
            if (rw && !busy_prev) mmem[ra] = rd;
            if (rst_ && n_m > done_edge(s_m, g_m)) begin
                s_m = n_m; g_m = gd; merr = 1'b0;
                for (int j = 0; j < NB; j++) snap[j] = mmem[j];
            end
            if (rw && busy_prev) merr = 1'b1;
            eb  = (n_m >= s_m) && (n_m <= done_edge(s_m, g_m));
            edn = (n_m == done_edge(s_m, g_m));
            dd  = n_m - s_m - 2;
            ev  = 1'b0; el = 1'b0;
            if (dd >= 0 && (dd % (g_m + 1)) == 0 && (dd / (g_m + 1)) < NB) begin
                k = dd / (g_m + 1);
                ev = 1'b1; el = (k == NB - 1); mdata = snap[k];
            end
            chk($sformatf("rand_cyc%0d", i), 64'(outs()), 64'({eb, ev, el, edn, merr, mdata}));
        end
        wr_en_in = 0; start_in = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
